// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: two-entry (main + skid) FIFO with valid/ready handshake and flush.
// Optional macro IFID_ILLEGAL_CHK_EN adds a per-entry illegal-instruction flag.
module if_id_pipe_reg #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h00000013)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] inst_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic            id_ready,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] pc_out,
    output logic            out_valid,
    output logic            illegal_out
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    typedef struct packed {
`ifdef IFID_ILLEGAL_CHK_EN
        logic            ill;
`endif
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } entry_t;

    occ_e   state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   accept;
    logic   pop;

    assign accept = in_valid & in_ready & ~flush;
    assign pop    = out_valid & id_ready;

    always_comb begin
        in_entry      = '0;
        in_entry.inst = inst_in;
        in_entry.pc   = pc_in;
`ifdef IFID_ILLEGAL_CHK_EN
        in_entry.ill  = (inst_in[1:0] != 2'b11) || (inst_in == '0);
`endif
    end

    // State register. Reset has priority over flush.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY:   if (accept) state_d = ONE;
                ONE:     if (accept && !pop) state_d = TWO;
                         else if (pop && !accept) state_d = EMPTY;
                TWO:     if (pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Outputs decode registered state only; in_ready has no path from id_ready.
    always_comb begin
        out_valid = (state_q != EMPTY);
        in_ready  = (state_q != TWO);
        inst_out  = out_valid ? main_q.inst : NOP_INST;
        pc_out    = main_q.pc;
`ifdef IFID_ILLEGAL_CHK_EN
        illegal_out = out_valid & main_q.ill;
`else
        illegal_out = 1'b0;
`endif
    end

    // Entry storage only loads on accept/pop, so idle-cycle X on the inputs never lands.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            main_d = '0;
            skid_d = '0;
        end else begin
            unique case (state_q)
                EMPTY:   if (accept) main_d = in_entry;
                ONE:     if (accept && pop) main_d = in_entry;
                         else if (accept) skid_d = in_entry;
                TWO:     if (pop) main_d = skid_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: entry storage is reset explicitly because pc_out must read 0 straight after reset.
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Self-checking bench for if_id_pipe_reg: directed vector table, illegal-flag sequence, random vs queue model.
module tb_if_id_pipe_reg;

    localparam logic [31:0] NOP = 32'h00000013;
`ifdef IFID_ILLEGAL_CHK_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, id_ready;
    logic [31:0] inst_in, pc_in;
    logic        in_ready, out_valid, illegal_out;
    logic [31:0] inst_out, pc_out;

    always #5 clk = ~clk;

    if_id_pipe_reg #(.XLEN(32), .NOP_INST(NOP)) dut (
        .clk(clk), .reset(reset), .inst_in(inst_in), .pc_in(pc_in),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush), .id_ready(id_ready),
        .inst_out(inst_out), .pc_out(pc_out), .out_valid(out_valid), .illegal_out(illegal_out)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic iv, input logic [31:0] inst,
                         input logic [31:0] pc, input logic fl, input logic idr);
        reset = rst; in_valid = iv; inst_in = inst; pc_in = pc; flush = fl; id_ready = idr;
    endtask

    typedef struct {
        logic        rst, iv;
        logic [31:0] inst, pc;
        logic        fl, idr;
        logic        ov;
        logic [31:0] inst_o, pc_o;
        logic        ir;
    } vec_t;

    function automatic vec_t mk(logic rst, logic iv, logic [31:0] inst, logic [31:0] pc,
                                logic fl, logic idr, logic ov, logic [31:0] inst_o,
                                logic [31:0] pc_o, logic ir);
        vec_t r;
        r.rst = rst; r.iv = iv; r.inst = inst; r.pc = pc; r.fl = fl; r.idr = idr;
        r.ov = ov; r.inst_o = inst_o; r.pc_o = pc_o; r.ir = ir;
        return r;
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        ill;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_last_pc;

    initial begin
        vec_t vecs[$];
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset with in_valid high
        vecs.push_back(mk(1, 1, 32'h00500093, 32'h100, 0, 1,  0, NOP, 32'h0, 1));
        vecs.push_back(mk(1, 1, 32'h00500093, 32'h100, 0, 1,  0, NOP, 32'h0, 1));
        // Streaming at full throughput
        vecs.push_back(mk(0, 1, 32'h00500093, 32'h0,   0, 1,  1, 32'h00500093, 32'h0, 1));
        vecs.push_back(mk(0, 1, 32'h00a00113, 32'h4,   0, 1,  1, 32'h00a00113, 32'h4, 1));
        vecs.push_back(mk(0, 1, 32'h002081b3, 32'h8,   0, 1,  1, 32'h002081b3, 32'h8, 1));
        vecs.push_back(mk(0, 0, 32'h0,        32'h0,   0, 1,  0, NOP, 32'h8, 1));
        // Stall into skid, then drain in order
        vecs.push_back(mk(0, 1, 32'h00100093, 32'h10,  0, 0,  1, 32'h00100093, 32'h10, 1));
        vecs.push_back(mk(0, 1, 32'h00200093, 32'h14,  0, 0,  1, 32'h00100093, 32'h10, 0));
        vecs.push_back(mk(0, 1, 32'h00300093, 32'h18,  0, 0,  1, 32'h00100093, 32'h10, 0));
        vecs.push_back(mk(0, 1, 32'h00300093, 32'h18,  0, 1,  1, 32'h00200093, 32'h14, 1));
        vecs.push_back(mk(0, 1, 32'h00300093, 32'h18,  0, 1,  1, 32'h00300093, 32'h18, 1));
        vecs.push_back(mk(0, 0, 32'h0,        32'h0,   0, 1,  0, NOP, 32'h18, 1));
        // Flush while full, with an incoming offer
        vecs.push_back(mk(0, 1, 32'h00400093, 32'h20,  0, 0,  1, 32'h00400093, 32'h20, 1));
        vecs.push_back(mk(0, 1, 32'h00500113, 32'h24,  0, 0,  1, 32'h00400093, 32'h20, 0));
        vecs.push_back(mk(0, 1, 32'h00600193, 32'h28,  1, 1,  0, NOP, 32'h0, 1));
        vecs.push_back(mk(0, 0, 32'h0,        32'h0,   0, 1,  0, NOP, 32'h0, 1));
        vecs.push_back(mk(0, 1, 32'h00700213, 32'h40,  0, 1,  1, 32'h00700213, 32'h40, 1));
        vecs.push_back(mk(0, 0, 32'h0,        32'h0,   0, 1,  0, NOP, 32'h40, 1));
        // Reset while full and stalled (reset beats flush)
        vecs.push_back(mk(0, 1, 32'h00800293, 32'h50,  0, 0,  1, 32'h00800293, 32'h50, 1));
        vecs.push_back(mk(0, 1, 32'h00900313, 32'h54,  0, 0,  1, 32'h00800293, 32'h50, 0));
        vecs.push_back(mk(1, 1, 32'h00a00393, 32'h58,  1, 0,  0, NOP, 32'h0, 1));
        vecs.push_back(mk(0, 0, 32'h0,        32'h0,   0, 1,  0, NOP, 32'h0, 1));
        vecs.push_back(mk(0, 1, 32'h00b00413, 32'h60,  0, 1,  1, 32'h00b00413, 32'h60, 1));
        // Flush while empty drops the offer and clears pc_out
        vecs.push_back(mk(0, 0, 32'h0,        32'h0,   0, 1,  0, NOP, 32'h60, 1));
        vecs.push_back(mk(0, 1, 32'h00c00493, 32'h70,  1, 1,  0, NOP, 32'h0, 1));
        vecs.push_back(mk(0, 0, 32'h0,        32'h0,   0, 1,  0, NOP, 32'h0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].inst, vecs[i].pc, vecs[i].fl, vecs[i].idr);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].ov});
            check($sformatf("vec%0d inst_out", i), inst_out, vecs[i].inst_o);
            check($sformatf("vec%0d pc_out", i), pc_out, vecs[i].pc_o);
            check($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].ir});
            check($sformatf("vec%0d illegal_out", i), {31'b0, illegal_out}, 32'h0);
        end

        // Illegal flag: all-zero inst, then a legal NOP, then an illegal entry through the skid
        drive(0, 1, 32'h00000000, 32'h80, 0, 1);
        @(posedge clk); #1;
        check("ill zero inst_out", inst_out, 32'h0);
        check("ill zero flag", {31'b0, illegal_out}, {31'b0, ILL_EN});
        drive(0, 1, 32'h00000013, 32'h84, 0, 1);
        @(posedge clk); #1;
        check("ill nop pc_out", pc_out, 32'h84);
        check("ill nop flag", {31'b0, illegal_out}, 32'h0);
        drive(0, 1, 32'h00000002, 32'h88, 0, 0);
        @(posedge clk); #1;
        check("ill skid head flag", {31'b0, illegal_out}, 32'h0);
        check("ill skid in_ready", {31'b0, in_ready}, 32'h0);
        drive(0, 0, 32'h0, 32'h0, 0, 1);
        @(posedge clk); #1;
        check("ill skid pc_out", pc_out, 32'h88);
        check("ill skid flag", {31'b0, illegal_out}, {31'b0, ILL_EN});
        drive(0, 0, 32'h0, 32'h0, 1, 1);
        @(posedge clk); #1;
        check("ill flush flag", {31'b0, illegal_out}, 32'h0);
        check("ill flush out_valid", {31'b0, out_valid}, 32'h0);

        // Random traffic against a queue model of the two-entry FIFO
        mq.delete();
        m_last_pc = 32'h0;
        for (int c = 0; c < 600; c++) begin
            logic        r_rst, r_iv, r_fl, r_idr, m_ready, m_pop;
            logic [31:0] r_inst, r_pc, exp_inst, exp_pc;
            logic        exp_ov, exp_ill;
            ent_t        e;
            r_rst  = (c == 0) || ($urandom_range(0, 99) < 2);
            r_fl   = ($urandom_range(0, 99) < 8);
            r_iv   = ($urandom_range(0, 99) < 70);
            r_idr  = ($urandom_range(0, 99) < 60);
            r_inst = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            r_pc   = $urandom & 32'hffff_fffc;
            drive(r_rst, r_iv, r_inst, r_pc, r_fl, r_idr);
            #1;
            m_ready = (mq.size() < 2);
            if (c != 0) check($sformatf("rnd%0d pre in_ready", c), {31'b0, in_ready}, {31'b0, m_ready});
            @(posedge clk);
            if (r_rst || r_fl) begin
                mq.delete();
                m_last_pc = 32'h0;
            end else begin
                m_pop = (mq.size() > 0) && r_idr;
                if (m_pop) void'(mq.pop_front());
                if (r_iv && m_ready) begin
                    e.inst = r_inst;
                    e.pc   = r_pc;
                    e.ill  = (r_inst[1:0] != 2'b11) || (r_inst == 32'h0);
                    mq.push_back(e);
                end
                if (mq.size() > 0) m_last_pc = mq[0].pc;
            end
            exp_ov   = (mq.size() > 0);
            exp_inst = exp_ov ? mq[0].inst : NOP;
            exp_pc   = m_last_pc;
            exp_ill  = exp_ov && mq[0].ill && ILL_EN;
            #1;
            check($sformatf("rnd%0d out_valid", c), {31'b0, out_valid}, {31'b0, exp_ov});
            check($sformatf("rnd%0d inst_out", c), inst_out, exp_inst);
            check($sformatf("rnd%0d pc_out", c), pc_out, exp_pc);
            check($sformatf("rnd%0d illegal_out", c), {31'b0, illegal_out}, {31'b0, exp_ill});
            check($sformatf("rnd%0d in_ready", c), {31'b0, in_ready}, {31'b0, (mq.size() < 2)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
